psel_rr_multi: RTL and testbench

Parametrised round-robin priority selector granting up to NUM_GNT of WIDTH requesters per cycle, searching upward with wrap-around from a registered priority pointer. Successor to the single-grant rotating selector. Generalised to multiple grants per cycle, non-power-of-two WIDTH, and a selectable pointer-update mode (blind rotate or advance-past-last-grant), plus a pointer lock. Used for issue-slot selection, CDB/writeback arbitration and free-list style multi-pick.

---
 rtl/psel_pkg.sv | 19 +
 rtl/psel_rr_find.sv | 36 +++
 rtl/psel_rr_multi.sv | 108 ++++++++++
 tb/tb_psel_rr_multi.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/psel_pkg.sv
// Shared types and width helpers for the multi-grant round-robin selector.
package psel_pkg;

    typedef enum logic {
        PSEL_ROTATE   = 1'b0,
        PSEL_LAST_GNT = 1'b1
    } psel_mode_e;

    // Index width; a floor of 1 keeps ports legal for degenerate sizes.
    function automatic int idx_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    // Width of a grant counter able to hold 0..num_gnt.
    function automatic int cnt_w(input int num_gnt);
        return (num_gnt > 0) ? $clog2(num_gnt + 1) : 1;
    endfunction

endpackage

// File: rtl/psel_rr_find.sv
// First unmasked request at or after start_i, wrapping mod WIDTH.
module psel_rr_find #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 2
) (
    input  logic [WIDTH-1:0] req_i,
    input  logic [WIDTH-1:0] mask_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    logic [WIDTH-1:0] avail;
    logic [WIDTH-1:0] sh;
    logic             hit;
    int               pos;

    always_comb begin
        avail = req_i & ~mask_i;
        sh    = '0;
        hit   = 1'b0;
        pos   = 0;
        idx_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pos = int'(start_i) + i;
            if (pos >= WIDTH) pos = pos - WIDTH;
            sh = avail >> pos;
            if (!hit && sh[0]) begin
                hit   = 1'b1;
                idx_o = IDX_W'(pos);
            end
        end
        found_o = hit;
    end

endmodule

// File: rtl/psel_rr_multi.sv
// Round-robin selector granting up to NUM_GNT requesters per cycle from a
// registered priority pointer, with rotate or advance-past-last-grant update.
module psel_rr_multi
    import psel_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int NUM_GNT = 1,
    parameter int MODE    = 0,
    parameter int IDX_W   = idx_w(WIDTH)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [WIDTH-1:0]                req,
    input  logic                            en,
    input  logic                            lock,
    output logic [WIDTH-1:0]                gnt,
    output logic [NUM_GNT-1:0][IDX_W-1:0]   gnt_idx,
    output logic [NUM_GNT-1:0]              gnt_valid,
    output logic [cnt_w(NUM_GNT)-1:0]       gnt_cnt,
    output logic [IDX_W-1:0]                ptr
);

    localparam int         CNT_W  = cnt_w(NUM_GNT);
    localparam psel_mode_e MODE_E = (MODE == 1) ? PSEL_LAST_GNT : PSEL_ROTATE;

    if (WIDTH < 2) begin : g_chk_width
        $error("psel_rr_multi: WIDTH must be >= 2");
    end
    if (NUM_GNT < 1 || NUM_GNT > WIDTH) begin : g_chk_ngnt
        $error("psel_rr_multi: NUM_GNT must be in 1..WIDTH");
    end
    if (MODE != 0 && MODE != 1) begin : g_chk_mode
        $error("psel_rr_multi: MODE must be 0 or 1");
    end

    logic [IDX_W-1:0]              ptr_q, ptr_d;
    logic [NUM_GNT-1:0][IDX_W-1:0] f_idx;
    logic [NUM_GNT-1:0]            f_found;
    logic [IDX_W-1:0]              last_idx;

    function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] v);
        if (v == IDX_W'(WIDTH - 1)) return '0;
        return v + IDX_W'(1);
    endfunction

    // Each slot masks out every grant made by the slots ahead of it.
    for (genvar k = 0; k < NUM_GNT; k++) begin : g_slot
        logic [WIDTH-1:0] mask_in;
        logic [WIDTH-1:0] mask_out;

        if (k == 0) begin : g_first
            assign mask_in = '0;
        end else begin : g_next
            assign mask_in = g_slot[k-1].mask_out;
        end

        psel_rr_find #(
            .WIDTH (WIDTH),
            .IDX_W (IDX_W)
        ) u_find (
            .req_i   (req),
            .mask_i  (mask_in),
            .start_i (ptr_q),
            .idx_o   (f_idx[k]),
            .found_o (f_found[k])
        );

        assign mask_out = mask_in | (f_found[k] ? (WIDTH'(1) << f_idx[k]) : '0);
    end

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = '0;
        gnt_cnt   = '0;
        last_idx  = '0;
        if (en) begin
            for (int k = 0; k < NUM_GNT; k++) begin
                if (f_found[k]) begin
                    gnt          = gnt | (WIDTH'(1) << f_idx[k]);
                    gnt_idx[k]   = f_idx[k];
                    gnt_valid[k] = 1'b1;
                    gnt_cnt      = gnt_cnt + CNT_W'(1);
                    last_idx     = f_idx[k];
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (en && !lock) begin
            if (MODE_E == PSEL_ROTATE) begin
                ptr_d = inc_wrap(ptr_q);
            end else if (gnt_cnt != '0) begin
                ptr_d = inc_wrap(last_idx);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;

endmodule

// File: tb/tb_psel_rr_multi.sv
// Directed bench for psel_rr_multi across three configurations sharing a clock.
module tb_psel_rr_multi;

    logic clock;
    logic rst_a, rst_b, rst_c;

    // A: WIDTH=4 NUM_GNT=1 MODE=0
    logic [3:0]      req_a;
    logic            en_a, lock_a;
    logic [3:0]      gnt_a;
    logic [0:0][1:0] idx_a;
    logic [0:0]      vld_a;
    logic [0:0]      cnt_a;
    logic [1:0]      ptr_a;

    // B: WIDTH=8 NUM_GNT=2 MODE=1
    logic [7:0]      req_b;
    logic            en_b, lock_b;
    logic [7:0]      gnt_b;
    logic [1:0][2:0] idx_b;
    logic [1:0]      vld_b;
    logic [1:0]      cnt_b;
    logic [2:0]      ptr_b;

    // C: WIDTH=6 NUM_GNT=3 MODE=0
    logic [5:0]      req_c;
    logic            en_c, lock_c;
    logic [5:0]      gnt_c;
    logic [2:0][2:0] idx_c;
    logic [2:0]      vld_c;
    logic [1:0]      cnt_c;
    logic [2:0]      ptr_c;

    psel_rr_multi #(.WIDTH(4), .NUM_GNT(1), .MODE(0)) dut_a (
        .clock(clock), .reset(rst_a), .req(req_a), .en(en_a), .lock(lock_a),
        .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(vld_a), .gnt_cnt(cnt_a), .ptr(ptr_a));

    psel_rr_multi #(.WIDTH(8), .NUM_GNT(2), .MODE(1)) dut_b (
        .clock(clock), .reset(rst_b), .req(req_b), .en(en_b), .lock(lock_b),
        .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(vld_b), .gnt_cnt(cnt_b), .ptr(ptr_b));

    psel_rr_multi #(.WIDTH(6), .NUM_GNT(3), .MODE(0)) dut_c (
        .clock(clock), .reset(rst_c), .req(req_c), .en(en_c), .lock(lock_c),
        .gnt(gnt_c), .gnt_idx(idx_c), .gnt_valid(vld_c), .gnt_cnt(cnt_c), .ptr(ptr_c));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int          errors = 0;
    int          checks = 0;
    logic [63:0] sb[$];

    task automatic push(input logic [63:0] v);
        sb.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs);
        logic [63:0] exp_v;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got %0h", tag, obs);
        end else begin
            exp_v = sb.pop_front();
            assert (obs === exp_v) else begin
                errors++;
                $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    int exp_gnt_a [5] = '{1, 2, 4, 8, 1};

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        req_a = '0; en_a = 1'b0; lock_a = 1'b0;
        req_b = '0; en_b = 1'b0; lock_b = 1'b0;
        req_c = '0; en_c = 1'b0; lock_c = 1'b0;

        // Reset state
        push(0); #2; chk("rst_ptr_a", 64'(ptr_a));
        push(0); chk("rst_ptr_b", 64'(ptr_b));
        push(0); chk("rst_ptr_c", 64'(ptr_c));
        push(0); chk("rst_gnt_a_en0", 64'(gnt_a));

        // Reset held wins over an enabled update; grants reflect ptr=0
        en_a = 1'b1; req_a = 4'b1111;
        push(4'b0001); #1; chk("rst_gnt_a", 64'(gnt_a));
        push(0); step(); chk("rst_hold_ptr_a", 64'(ptr_a));
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

        // A: blind rotation with all requesting
        for (int i = 0; i < 5; i++) begin
            push(64'(exp_gnt_a[i])); chk($sformatf("rot_gnt_a%0d", i), 64'(gnt_a));
            push(64'(i % 4));        chk($sformatf("rot_ptr_a%0d", i), 64'(ptr_a));
            step();
        end

        // A: en=0 kills grants and freezes pointer
        en_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(0); #1; chk($sformatf("en0_gnt_a%0d", i), 64'(gnt_a));
            push(0); chk($sformatf("en0_vld_a%0d", i), 64'(vld_a));
            push(0); chk($sformatf("en0_cnt_a%0d", i), 64'(cnt_a));
            push(1); chk($sformatf("en0_ptr_a%0d", i), 64'(ptr_a));
            step();
        end

        // A: reach ptr=3, then async reset between edges
        en_a = 1'b1;
        step(); step();
        push(3); chk("pre_arst_ptr_a", 64'(ptr_a));
        #2; rst_a = 1'b0; #1;
        push(0); chk("arst_ptr_a", 64'(ptr_a));
        step();
        push(0); chk("arst_edge_ptr_a", 64'(ptr_a));
        #2; rst_a = 1'b1;
        step();
        push(1); chk("arst_rel_ptr_a", 64'(ptr_a));
        en_a = 1'b0;

        // B: last-grant mode, two grants
        en_b = 1'b1; req_b = 8'b1010_0100; #1;
        push(8'b0010_0100);      chk("lg_gnt_b0", 64'(gnt_b));
        push((5 << 3) | 2);      chk("lg_idx_b0", 64'(idx_b));
        push(2);                 chk("lg_cnt_b0", 64'(cnt_b));
        push(2'b11);             chk("lg_vld_b0", 64'(vld_b));
        step();
        push(6);                 chk("lg_ptr_b1", 64'(ptr_b));
        push(8'b1000_0100);      chk("lg_gnt_b1", 64'(gnt_b));
        push((2 << 3) | 7);      chk("lg_idx_b1", 64'(idx_b));
        step();
        push(3);                 chk("lg_ptr_b2", 64'(ptr_b));

        // B: no requests -> no grants, pointer holds
        req_b = '0; #1;
        push(0); chk("noreq_cnt_b", 64'(cnt_b));
        push(0); chk("noreq_idx_b", 64'(idx_b));
        push(0); chk("noreq_vld_b", 64'(vld_b));
        step();
        push(3); chk("noreq_ptr_b", 64'(ptr_b));

        // B: lock keeps granting but holds pointer
        req_b = 8'hFF; lock_b = 1'b1; #1;
        push(8'b0001_1000);  chk("lock_gnt_b", 64'(gnt_b));
        push(2);             chk("lock_cnt_b", 64'(cnt_b));
        step();
        push(3);             chk("lock_ptr_b", 64'(ptr_b));
        lock_b = 1'b0;
        step();
        push(5);             chk("unlock_ptr_b", 64'(ptr_b));
        en_b = 1'b0;

        // C: single grant leaves upper slots empty
        en_c = 1'b1; req_c = 6'b000100; #1;
        push(3'b001); chk("one_vld_c", 64'(vld_c));
        push(2);      chk("one_idx_c", 64'(idx_c));
        push(1);      chk("one_cnt_c", 64'(cnt_c));

        // C: non-power-of-two wrap, three grants
        req_c = 6'b100011; #1;
        push((5 << 6) | (1 << 3) | 0); chk("w6_idx_c_p0", 64'(idx_c));
        for (int i = 0; i < 5; i++) step();
        push(5);                       chk("w6_ptr_c5", 64'(ptr_c));
        push((1 << 6) | (0 << 3) | 5); chk("w6_idx_c_p5", 64'(idx_c));
        push(3'b111);                  chk("w6_vld_c", 64'(vld_c));
        push(6'b100011);               chk("w6_gnt_c", 64'(gnt_c));
        push(3);                       chk("w6_cnt_c", 64'(cnt_c));
        step();
        push(0);                       chk("w6_wrap_ptr_c", 64'(ptr_c));
        en_c = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
